// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and constants for the multicycle MIPS control FSM
package mips_ctrl_pkg;

  localparam int OPW = 6;
  localparam int STW = 4;

  typedef enum logic [STW-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Raw per-state control; mem_write/ir_write/pc_write are qualified later by mem_ready.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '0;

  function automatic logic op_supported(input logic [OPW-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bundle between the FSM and the multicycle datapath
interface multicycle_controller_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           mem_req;
  logic           mem_write;
  logic           iord;
  logic           ir_write;
  logic           pc_en;
  logic [1:0]     pc_src;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     aluop;
  logic           reg_write;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           illegal_op;
  logic [STW-1:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           aluop, reg_write, reg_dst, mem_to_reg, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
           aluop, reg_write, reg_dst, mem_to_reg, illegal_op, state
  );
endinterface

// File: rtl/ctrl_output_decoder.sv
// rtl/ctrl_output_decoder.sv - Moore decode of FSM state into the raw control word
module ctrl_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = CW_IDLE;
    case (state)
      S_FETCH: begin
        cw.mem_req   = 1'b1;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
        cw.pc_src    = PC_SRC_ALU;
        cw.alu_src_b = SRCB_FOUR;
        cw.aluop     = ALUOP_ADD;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        cw.alu_src_b = SRCB_IMM_SH2;
        cw.aluop     = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.aluop     = ALUOP_ADD;
      end
      S_MEMRD: begin
        cw.mem_req = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        cw.mem_req   = 1'b1;
        cw.iord      = 1'b1;
        cw.mem_write = 1'b1;
      end
      S_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REGB;
        cw.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_REGB;
        cw.aluop     = ALUOP_SUB;
        cw.branch    = 1'b1;
        cw.pc_src    = PC_SRC_ALUOUT;
      end
      S_ADDIEX: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.aluop     = ALUOP_ADD;
      end
      S_ADDIWB: begin
        cw.reg_write = 1'b1;
      end
      S_JUMP: begin
        cw.pc_src   = PC_SRC_JUMP;
        cw.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multicycle MIPS core
// Holds the state register and next-state logic; outputs decode from state, qualified by mem_ready/zero.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_controller_if.master bus
);

  state_t         state_q;
  state_t         state_d;
  ctrl_word_t     cw;
  logic [OPW-1:0] opcode;
  logic           mem_ready;

  assign opcode    = bus.opcode;
  assign mem_ready = bus.mem_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // IR is stable, so the opcode seen in DECODE is still valid here.
        if (opcode == OP_SW)      state_d = S_MEMWR;
        else if (opcode == OP_LW) state_d = S_MEMRD;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  ctrl_output_decoder u_dec (
    .state (state_q),
    .cw    (cw)
  );

  // Everything is held at zero while reset is asserted so an aborted instruction never writes.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.aluop      = 2'b00;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal_op = 1'b0;
    bus.state      = STW'(S_FETCH);
    if (reset_n) begin
      bus.mem_req    = cw.mem_req;
      bus.mem_write  = cw.mem_write & mem_ready;
      bus.iord       = cw.iord;
      bus.ir_write   = cw.ir_write & mem_ready;
      // A PC write tied to a memory access (FETCH) waits for the access to complete.
      bus.pc_en      = (cw.pc_write & (~cw.mem_req | mem_ready)) | (cw.branch & bus.zero);
      bus.pc_src     = cw.pc_src;
      bus.alu_src_a  = cw.alu_src_a;
      bus.alu_src_b  = cw.alu_src_b;
      bus.aluop      = cw.aluop;
      bus.reg_write  = cw.reg_write;
      bus.reg_dst    = cw.reg_dst;
      bus.mem_to_reg = cw.mem_to_reg;
      bus.illegal_op = (state_q == S_DECODE) && !op_supported(opcode);
      bus.state      = STW'(state_q);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - bench for multicycle_controller
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq;
    logic       mwr;
    logic       iord;
    logic       irw;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic  clk;
  logic  reset_n;
  int    total;
  int    bad;
  vec_t  vecs[$];
  outs_t act;
  int    n;

  multicycle_controller_if #(.OPW(6), .STW(4)) bus ();

  multicycle_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic outs_t mk(input int st, input int mreq, input int mwr, input int iord,
                               input int irw, input int pcen, input int pcsrc, input int sa,
                               input int sb, input int aop, input int rw, input int rd,
                               input int m2r, input int ill);
    outs_t o;
    o.st    = 4'(st);
    o.mreq  = 1'(mreq);
    o.mwr   = 1'(mwr);
    o.iord  = 1'(iord);
    o.irw   = 1'(irw);
    o.pcen  = 1'(pcen);
    o.pcsrc = 2'(pcsrc);
    o.sa    = 1'(sa);
    o.sb    = 2'(sb);
    o.aop   = 2'(aop);
    o.rw    = 1'(rw);
    o.rd    = 1'(rd);
    o.m2r   = 1'(m2r);
    o.ill   = 1'(ill);
    return o;
  endfunction

  task automatic add(input int rst, input logic [5:0] op, input int z, input int rdy, input outs_t e);
    vec_t v;
    v.rst_n = 1'(rst);
    v.op    = op;
    v.zero  = 1'(z);
    v.rdy   = 1'(rdy);
    v.exp   = e;
    vecs.push_back(v);
  endtask

  function automatic outs_t sample();
    return {bus.state, bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en,
            bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.illegal_op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, a, e);
    end
  endtask

  // Cycles from FETCH back to FETCH; entered and left at a sample point in FETCH.
  task automatic lat(input logic [5:0] op, input int exp, input string nm);
    bus.opcode    = op;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (bus.state == 4'd0) break;
      n++;
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    bus.opcode    = OP_LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;

    // reset held: every strobe and select zero
    add(0, OP_LW,   1, 1, mk(0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0));
    add(0, OP_LW,   1, 1, mk(0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0));
    // lw, no waits: 0 1 2 3 4
    add(1, OP_LW,   1, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_LW,   1, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_LW,   1, 1, mk(2, 0,0,0,0,0, 0, 1,2,0, 0,0,0,0));
    add(1, OP_LW,   1, 1, mk(3, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0));
    add(1, OP_LW,   1, 1, mk(4, 0,0,0,0,0, 0, 0,0,0, 1,0,1,0));
    // sw: fetch wait, then MEMWR held 3 cycles
    add(1, OP_SW,   0, 0, mk(0, 1,0,0,0,0, 0, 0,1,0, 0,0,0,0));
    add(1, OP_SW,   0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_SW,   0, 0, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_SW,   0, 0, mk(2, 0,0,0,0,0, 0, 1,2,0, 0,0,0,0));
    add(1, OP_SW,   0, 0, mk(5, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0));
    add(1, OP_SW,   0, 0, mk(5, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0));
    add(1, OP_SW,   0, 1, mk(5, 1,1,1,0,0, 0, 0,0,0, 0,0,0,0));
    // R-type, zero high must not leak into pc_en
    add(1, OP_RTYPE,1, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_RTYPE,1, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_RTYPE,1, 1, mk(6, 0,0,0,0,0, 0, 1,0,2, 0,0,0,0));
    add(1, OP_RTYPE,1, 1, mk(7, 0,0,0,0,0, 0, 0,0,0, 1,1,0,0));
    // beq taken
    add(1, OP_BEQ,  0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_BEQ,  0, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_BEQ,  1, 1, mk(8, 0,0,0,0,1, 1, 1,0,1, 0,0,0,0));
    // beq not taken
    add(1, OP_BEQ,  0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_BEQ,  1, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_BEQ,  0, 1, mk(8, 0,0,0,0,0, 1, 1,0,1, 0,0,0,0));
    // addi
    add(1, OP_ADDI, 0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_ADDI, 0, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_ADDI, 0, 1, mk(9, 0,0,0,0,0, 0, 1,2,0, 0,0,0,0));
    add(1, OP_ADDI, 0, 1, mk(10,0,0,0,0,0, 0, 0,0,0, 1,0,0,0));
    // j
    add(1, OP_J,    0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_J,    0, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_J,    0, 1, mk(11,0,0,0,0,1, 2, 0,0,0, 0,0,0,0));
    // illegal opcode: single pulse in DECODE, back to FETCH
    add(1, 6'h3f,   0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, 6'h3f,   0, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,1));
    add(1, 6'h3f,   0, 0, mk(0, 1,0,0,0,0, 0, 0,1,0, 0,0,0,0));
    // reset asserted while waiting in MEMRD
    add(1, OP_LW,   0, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_LW,   0, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));
    add(1, OP_LW,   0, 1, mk(2, 0,0,0,0,0, 0, 1,2,0, 0,0,0,0));
    add(1, OP_LW,   0, 0, mk(3, 1,0,1,0,0, 0, 0,0,0, 0,0,0,0));
    add(0, OP_LW,   1, 0, mk(0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0));
    add(0, OP_LW,   1, 1, mk(0, 0,0,0,0,0, 0, 0,0,0, 0,0,0,0));
    add(1, OP_LW,   1, 1, mk(0, 1,0,0,1,1, 0, 0,1,0, 0,0,0,0));
    add(1, OP_LW,   1, 1, mk(1, 0,0,0,0,0, 0, 0,3,0, 0,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset_n       = vecs[i].rst_n;
      bus.opcode    = vecs[i].op;
      bus.zero      = vecs[i].zero;
      bus.mem_ready = vecs[i].rdy;
      #1;
      act = sample();
      chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
    end

    // Fetch stall: state and strobes hold until memory is ready
    @(negedge clk);
    reset_n       = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fetch_stall%0d", k), {28'd0, bus.state}, 32'd0);
      chk($sformatf("fetch_stall_strobes%0d", k), {30'd0, bus.ir_write, bus.pc_en}, 32'd0);
      @(negedge clk);
      #1;
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("fetch_ready_strobes", {30'd0, bus.ir_write, bus.pc_en}, 32'd3);

    lat(OP_LW,    5, "lat_lw");
    lat(OP_SW,    4, "lat_sw");
    lat(OP_RTYPE, 4, "lat_rtype");
    lat(OP_ADDI,  4, "lat_addi");
    lat(OP_BEQ,   3, "lat_beq");
    lat(OP_J,     3, "lat_j");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
